alu_mc: RTL and testbench

Parametrised multi-cycle integer execute unit for the RISC-V core, succeeding the single-cycle combinational ALU. It executes all RV32I R/I-type arithmetic, logic, shift and compare operations, plus the M-extension multiply/divide/remainder operations. It sits between decode/register-read and writeback. Operands enter and results leave through valid/ready handshakes. Simple ops take one cycle; multiply and divide iterate one bit per cycle.

---
 rtl/alu_mc_if.sv | 28 ++
 rtl/alu_mc.sv | 159 +++++++++++++++
 tb/tb_alu_mc.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between register-read, the multi-cycle ALU and writeback.
interface alu_mc_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic            imm_sel;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, funct7, funct3, imm_sel, rs1_val, rs2_val, imm, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, funct7, funct3, imm_sel, rs1_val, rs2_val, imm, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle RV32I/M execute unit: single-cycle base ops, bit-serial multiply and
// restoring divide on magnitudes with a final sign fix-up.
module alu_mc #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input logic     clk,
  input logic     rst_n,
  alu_mc_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SHW-1:0]    r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opb;
  logic [XLEN-1:0]   r_result;
  logic [2:0]        r_fn3;
  logic              r_neg;

  // ---------------- accept-time decode ----------------
  logic [XLEN-1:0] w_a, w_b, w_mag_a, w_mag_b, w_simple, w_special_res;
  logic [SHW-1:0]  w_shamt;
  logic            w_is_m, w_alt, w_accept;
  logic            w_a_signed, w_b_signed, w_sa, w_sb;
  logic            w_div0, w_ovf, w_special, w_iter;

  assign w_a      = bus.rs1_val;
  assign w_b      = bus.imm_sel ? bus.imm : bus.rs2_val;
  assign w_shamt  = w_b[SHW-1:0];
  assign w_is_m   = (bus.funct7 == 7'h01) && !bus.imm_sel;
  assign w_alt    = (bus.funct7 == 7'h20);
  assign w_accept = bus.in_valid && (r_state == S_IDLE) && !bus.flush;

  // Signedness of each operand per M-ext funct3 (MULHSU: A signed, B unsigned).
  assign w_a_signed = (bus.funct3 == 3'd0) || (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2)
                   || (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
  assign w_b_signed = (bus.funct3 == 3'd0) || (bus.funct3 == 3'd1)
                   || (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
  assign w_sa       = w_a_signed && w_a[XLEN-1];
  assign w_sb       = w_b_signed && w_b[XLEN-1];
  assign w_mag_a    = w_sa ? -w_a : w_a;
  assign w_mag_b    = w_sb ? -w_b : w_b;

  assign w_div0    = (w_b == '0);
  assign w_ovf     = w_b_signed && (w_a == {1'b1, {(XLEN-1){1'b0}}}) && (w_b == '1);
  assign w_special = w_is_m && bus.funct3[2] && (w_div0 || w_ovf);
  assign w_iter    = w_is_m && !w_special;

  // funct3[1] distinguishes REM/REMU from DIV/DIVU.
  always_comb begin
    w_special_res = '0;
    if (w_div0) w_special_res = bus.funct3[1] ? w_a : '1;
    else        w_special_res = bus.funct3[1] ? '0  : w_a;
  end

  always_comb begin
    w_simple = '0;
    case (bus.funct3)
      3'd0:    w_simple = (w_alt && !bus.imm_sel) ? (w_a - w_b) : (w_a + w_b);
      3'd1:    w_simple = w_a << w_shamt;
      3'd2:    w_simple = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      3'd3:    w_simple = {{(XLEN-1){1'b0}}, (w_a < w_b)};
      3'd4:    w_simple = w_a ^ w_b;
      3'd5:    w_simple = w_alt ? XLEN'($signed(w_a) >>> w_shamt) : (w_a >> w_shamt);
      3'd6:    w_simple = w_a | w_b;
      default: w_simple = w_a & w_b;
    endcase
  end

  // ---------------- iteration datapath ----------------
  // Multiply: r_acc = {partial product, remaining multiplier bits}, shifted right each step.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_nxt, w_prod;
  logic [XLEN-1:0]   w_mul_res;

  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_prod    = r_neg ? -w_mul_nxt : w_mul_nxt;
  assign w_mul_res = (r_fn3 == 3'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // Divide: r_acc = {remainder, dividend/quotient}, shifted left with a trial subtract.
  logic [XLEN:0]     w_div_trial;
  logic [XLEN-1:0]   w_div_diff, w_div_sel, w_div_res;
  logic              w_div_ge;
  logic [2*XLEN-1:0] w_div_nxt;

  assign w_div_trial = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_ge    = (w_div_trial >= {1'b0, r_opb});
  assign w_div_diff  = w_div_trial[XLEN-1:0] - r_opb;
  assign w_div_nxt   = {(w_div_ge ? w_div_diff : w_div_trial[XLEN-1:0]),
                        r_acc[XLEN-2:0], w_div_ge};
  assign w_div_sel   = r_fn3[1] ? w_div_nxt[2*XLEN-1:XLEN] : w_div_nxt[XLEN-1:0];
  assign w_div_res   = r_neg ? -w_div_sel : w_div_sel;

  // ---------------- FSM ----------------
  // NOTE: every sequential process uses non-blocking assignments so all registers
  // update from the same pre-edge values; the datapath resets too, so no partial
  // result survives an asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          if (w_iter) w_state_nxt = bus.funct3[2] ? S_DIV : S_MUL;
          else        w_state_nxt = S_DONE;
        end
        S_MUL, S_DIV: if (r_cnt == '0) w_state_nxt = S_DONE;
        S_DONE:       if (bus.out_ready) w_state_nxt = S_IDLE;
        default:      w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (r_state == S_IDLE) && !bus.flush;
    bus.out_valid = (r_state == S_DONE);
    bus.busy      = (r_state != S_IDLE);
  end

  assign bus.result = r_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_fn3    <= '0;
      r_neg    <= 1'b0;
    end else if (!bus.flush) begin
      if (w_accept) begin
        if (w_iter) begin
          r_cnt <= SHW'(XLEN-1);
          r_acc <= {{XLEN{1'b0}}, w_mag_a};
          r_opb <= w_mag_b;
          r_fn3 <= bus.funct3;
          r_neg <= (bus.funct3[2] && bus.funct3[1]) ? w_sa : (w_sa ^ w_sb);
        end else begin
          r_result <= w_is_m ? w_special_res : w_simple;
        end
      end else if (r_state == S_MUL || r_state == S_DIV) begin
        r_acc <= (r_state == S_MUL) ? w_mul_nxt : w_div_nxt;
        if (r_cnt == '0) r_result <= (r_state == S_MUL) ? w_mul_res : w_div_res;
        else             r_cnt    <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: base ops, multiply/divide, special cases, backpressure,
// flush and asynchronous reset, on a 32-bit and a 16-bit instance.
module tb_alu_mc;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_mc_if #(.XLEN(32)) bus ();
  alu_mc_if #(.XLEN(16)) bus16 ();

  alu_mc #(.XLEN(32)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  alu_mc #(.XLEN(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one op, let it be accepted at the next rising edge, then scramble inputs.
  task automatic issue(input logic [6:0] f7, input logic [2:0] f3, input logic sel,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.funct7 = f7; bus.funct3 = f3; bus.imm_sel = sel;
    bus.rs1_val = a; bus.rs2_val = b; bus.imm = im;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.funct3 = ~f3;
    bus.rs1_val = 32'h1234_5678; bus.rs2_val = 32'h0000_0001; bus.imm = 32'h0000_0002;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                        input logic sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(f7, f3, sel, a, b, im);
    wait_valid(lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check(tag, bus.result, exp);
    take();
    check({tag, " idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    bus.flush = 0; bus.in_valid = 0; bus.funct7 = 0; bus.funct3 = 0; bus.imm_sel = 0;
    bus.rs1_val = 0; bus.rs2_val = 0; bus.imm = 0; bus.out_ready = 0;
    bus16.flush = 0; bus16.in_valid = 0; bus16.funct7 = 0; bus16.funct3 = 0; bus16.imm_sel = 0;
    bus16.rs1_val = 0; bus16.rs2_val = 0; bus16.imm = 0; bus16.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst busy",      {31'd0, bus.busy},      32'd0);
    check("rst result",    bus.result,             32'd0);
    check("rst16 result",  {16'd0, bus16.result},  32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Base ops
    run_op("ADD ovf",  7'h00, 3'd0, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h8000_0000, 1);
    run_op("ADDI f7",  7'h20, 3'd0, 1'b1, 32'd10, 32'd99, 32'd3, 32'd13, 1);
    run_op("SUB",      7'h20, 3'd0, 1'b0, 32'd10, 32'd3, 32'd0, 32'd7, 1);
    run_op("ADD f7x",  7'h05, 3'd0, 1'b0, 32'd10, 32'd3, 32'd0, 32'd13, 1);
    run_op("SRA",      7'h20, 3'd5, 1'b0, 32'h8000_0000, 32'h21, 32'h0, 32'hC000_0000, 1);
    run_op("SRL",      7'h00, 3'd5, 1'b0, 32'h8000_0000, 32'h4, 32'h0, 32'h0800_0000, 1);
    run_op("SLLI",     7'h00, 3'd1, 1'b1, 32'h1, 32'h0, 32'd31, 32'h8000_0000, 1);
    run_op("SLT",      7'h00, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'd1, 1);
    run_op("SLTU",     7'h00, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'd0, 1);
    run_op("XOR",      7'h00, 3'd4, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0FF0_0FF0, 1);
    run_op("OR",       7'h00, 3'd6, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'hFFF0_FFF0, 1);
    run_op("AND",      7'h00, 3'd7, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'hF000_F000, 1);

    // Multiply
    run_op("MULH",     7'h01, 3'd1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h4000_0000, 33);
    run_op("MULHSU",   7'h01, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 33);
    run_op("MULHU",    7'h01, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE, 33);
    run_op("MUL",      7'h01, 3'd0, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'h0, 32'hFFFF_FFEB, 33);

    // Divide
    run_op("DIV",      7'h01, 3'd4, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'hFFFF_FFFD, 33);
    run_op("REM",      7'h01, 3'd6, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'hFFFF_FFFF, 33);
    run_op("REM negB", 7'h01, 3'd6, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'h0, 32'd1, 33);
    run_op("DIVU",     7'h01, 3'd5, 1'b0, 32'd100, 32'd7, 32'h0, 32'd14, 33);
    run_op("REMU",     7'h01, 3'd7, 1'b0, 32'd100, 32'd7, 32'h0, 32'd2, 33);
    run_op("DIV by0",  7'h01, 3'd4, 1'b0, 32'd5, 32'd0, 32'h0, 32'hFFFF_FFFF, 1);
    run_op("REM by0",  7'h01, 3'd6, 1'b0, 32'd5, 32'd0, 32'h0, 32'd5, 1);
    run_op("DIVU by0", 7'h01, 3'd5, 1'b0, 32'd5, 32'd0, 32'h0, 32'hFFFF_FFFF, 1);
    run_op("DIV ovf",  7'h01, 3'd4, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1);
    run_op("REM ovf",  7'h01, 3'd6, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'd0, 1);

    // Backpressure: result held, no accept while DONE
    issue(7'h00, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0);
    wait_valid(lat);
    check("bp latency", 32'(lat), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.funct7 = 7'h00; bus.funct3 = 3'd0; bus.imm_sel = 1'b0;
    bus.rs1_val = 32'd9; bus.rs2_val = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp result",    bus.result,             32'd3);
      check("bp in_ready",  {31'd0, bus.in_ready},  32'd0);
      check("bp out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp release busy",     {31'd0, bus.busy},     32'd0);
    check("bp release in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp next valid",  {31'd0, bus.out_valid}, 32'd1);
    check("bp next result", bus.result,             32'd10);
    take();

    // Flush mid-divide
    issue(7'h01, 3'd5, 1'b0, 32'd100, 32'd7, 32'd0);
    repeat (9) @(posedge clk);
    @(negedge clk) bus.flush = 1'b1;
    #1;
    check("flush in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("flush busy pre", {31'd0, bus.busy},     32'd1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush busy",      {31'd0, bus.busy},      32'd0);
    check("flush out_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("flush no result", {31'd0, bus.out_valid}, 32'd0);

    // Flush and out_ready together in DONE
    issue(7'h00, 3'd4, 1'b0, 32'h5, 32'h3, 32'd0);
    wait_valid(lat);
    check("flushdone latency", 32'(lat), 32'd1);
    @(negedge clk);
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    check("flushdone valid", {31'd0, bus.out_valid}, 32'd0);
    check("flushdone busy",  {31'd0, bus.busy},      32'd0);
    run_op("post flush ADD", 7'h00, 3'd0, 1'b0, 32'd40, 32'd2, 32'd0, 32'd42, 1);

    // Asynchronous reset mid-multiply
    issue(7'h01, 3'd0, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'd0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst busy",      {31'd0, bus.busy},      32'd0);
    check("arst out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("arst result",    bus.result,             32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op("post rst MUL", 7'h01, 3'd0, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'h0, 32'hFFFF_FFEB, 33);

    // 16-bit instance multiply
    @(negedge clk);
    bus16.in_valid = 1'b1; bus16.funct7 = 7'h01; bus16.funct3 = 3'd0; bus16.imm_sel = 1'b0;
    bus16.rs1_val = 16'd7; bus16.rs2_val = 16'hFFFD; bus16.imm = 16'h0;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0; bus16.rs1_val = 16'h1111;
    lat = 1;
    while (!bus16.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("MUL16 latency", 32'(lat), 32'd17);
    check("MUL16", {16'd0, bus16.result}, 32'h0000_FFEB);
    @(negedge clk) bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    check("MUL16 idle", {31'd0, bus16.busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
